// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO.
// Optional feature macro: UART_RX_FRAMING_CHECK_EN (adds o_frame_err).
// Ports:
//   i_clk, i_rst     clock; async active-high reset
//   i_rx             serial line, idles high
//   i_pop            pop FIFO head (ignored when empty)
//   i_clr_err        clear sticky error flags
//   o_data/o_valid   FIFO head byte / non-empty
//   o_count          bytes held, 0..DEPTH
//   o_overrun        sticky: byte dropped on full FIFO
//   o_frame_err      sticky: bad stop bit (feature only)
//   o_busy           receiver inside a frame
module uart_rx_fifo #(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 9600,
  parameter int DEPTH       = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  input  logic                   i_pop,
  input  logic                   i_clr_err,
  output logic [7:0]             o_data,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overrun,
`ifdef UART_RX_FRAMING_CHECK_EN
  output logic                   o_frame_err,
`endif
  output logic                   o_busy
);

  localparam int CPB = clk_freq_hz / baud_rate;
  localparam int CW  = $clog2(CPB) + 1;
  localparam int AW  = $clog2(DEPTH);

  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [AW:0]   CAP  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_meta;
  logic          r_rx_s;
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [7:0]    r_mem [DEPTH];
  logic          r_overrun;

  logic          w_tick;
  logic          w_stop_hit;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [AW:0]   w_count;

  assign w_tick     = (r_cnt == '0);
  assign w_stop_hit = (r_state == STOP) && w_tick;

`ifdef UART_RX_FRAMING_CHECK_EN
  logic r_ferr;
  logic r_brk;
  logic w_ferr_set;

  assign w_push     = w_stop_hit && r_rx_s;
  assign w_ferr_set = w_stop_hit && !r_rx_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_ferr <= 1'b0;
    else if (w_ferr_set)
      r_ferr <= 1'b1;
    else if (i_clr_err)
      r_ferr <= 1'b0;
  end

  assign o_frame_err = r_ferr;
`else
  assign w_push = w_stop_hit;
`endif

  // Two-flop synchroniser; line idles high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_rx_s <= r_meta;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
`ifdef UART_RX_FRAMING_CHECK_EN
      r_brk   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
`ifdef UART_RX_FRAMING_CHECK_EN
          // After a bad stop bit, wait for the line to
          // go high before hunting for a start bit.
          if (r_brk) begin
            if (r_rx_s)
              r_brk <= 1'b0;
          end else if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= HALF;
          end
`else
          if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= HALF;
          end
`endif
        end
        START: begin
          if (w_tick) begin
            if (!r_rx_s) begin
              r_state <= DATA;
              r_cnt   <= FULL;
              r_idx   <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_cnt   <= FULL;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == 3'd7)
              r_state <= STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        STOP: begin
          // Leave at mid-stop so back-to-back
          // frames are caught.
          if (w_tick) begin
            r_state <= IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
            r_brk   <= !r_rx_s;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_count == CAP);
  assign w_pop   = i_pop && !w_empty;
  // A pop in the same cycle frees the slot.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (i_clr_err)
        r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  assign o_data    = w_empty ? 8'h00
                   : r_mem[r_rd_ptr[AW-1:0]];
  assign o_valid   = !w_empty;
  assign o_count   = w_count;
  assign o_overrun = r_overrun;
  assign o_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed + random frames against a
// queue-based model of the receiver FIFO.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int CPB   = 16;
  localparam int FRM   = 10 * CPB;
  // Push edge of a frame, counted in cycles from start bit.
  localparam int PUSH_N = 154;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_pop = 1'b0;
  logic       i_clr_err = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic [3:0] o_count;
  logic       o_overrun;
  logic       o_busy;
`ifdef UART_RX_FRAMING_CHECK_EN
  logic       o_frame_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  bit         m_ovr = 0;
  bit         m_ferr = 0;

  uart_rx_fifo #(
    .clk_freq_hz(16),
    .baud_rate  (1),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .i_pop      (i_pop),
    .i_clr_err  (i_clr_err),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_count    (o_count),
    .o_overrun  (o_overrun),
`ifdef UART_RX_FRAMING_CHECK_EN
    .o_frame_err(o_frame_err),
`endif
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag);
    logic [7:0] hd;
    hd = (q.size() > 0) ? q[0] : 8'h00;
    chk({tag, "_cnt"}, 32'(o_count), 32'(q.size()));
    chk({tag, "_vld"}, 32'(o_valid), 32'(q.size() > 0));
    chk({tag, "_dat"}, 32'(o_data), 32'(hd));
    chk({tag, "_ovr"}, 32'(o_overrun), 32'(m_ovr));
    chk({tag, "_bsy"}, 32'(o_busy), 32'd0);
`ifdef UART_RX_FRAMING_CHECK_EN
    chk({tag, "_fer"}, 32'(o_frame_err), 32'(m_ferr));
`endif
  endtask

  // Drive up to max_n cycles of a 10-bit frame.
  task automatic drive(input logic [7:0] b,
                       input logic stop_v,
                       input bit pop_at_stop,
                       input int max_n);
    logic [7:0] bb;
    bb = b;
    for (int n = 0; n < FRM && n < max_n; n++) begin
      int k;
      k = n / CPB;
      if (k == 0)
        i_rx = 1'b0;
      else if (k == 9)
        i_rx = stop_v;
      else
        i_rx = bb[k-1];
      i_pop = pop_at_stop && (n == PUSH_N);
      tick();
    end
    i_pop = 1'b0;
  endtask

  // Model of the effect of one completed frame.
  task automatic model_frame(input logic [7:0] b,
                             input logic stop_v,
                             input bit pop_at_stop);
`ifdef UART_RX_FRAMING_CHECK_EN
    if (!stop_v) begin
      m_ferr = 1;
      return;
    end
`endif
    if (pop_at_stop && q.size() > 0)
      void'(q.pop_front());
    if (q.size() < DEPTH)
      q.push_back(b);
    else
      m_ovr = 1;
  endtask

  task automatic frame(input logic [7:0] b,
                       input logic stop_v,
                       input bit pop_at_stop);
    drive(b, stop_v, pop_at_stop, FRM);
    i_rx = 1'b1;
    model_frame(b, stop_v, pop_at_stop);
    if (!stop_v)
      repeat (24) tick();
  endtask

  task automatic pop_n(input int n, input string tag);
    i_pop = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (q.size() > 0)
        void'(q.pop_front());
      verify(tag);
    end
    i_pop = 1'b0;
  endtask

  task automatic clr();
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    m_ovr = 0;
    m_ferr = 0;
  endtask

  task automatic glitch();
    bit seen;
    seen = 0;
    i_rx = 1'b0;
    repeat (4) begin
      tick();
      seen |= o_busy;
    end
    i_rx = 1'b1;
    repeat (16) begin
      tick();
      seen |= o_busy;
    end
    chk("glitch_busy_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #1;
    verify("rst");
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    verify("rst_rel");

    // First frame: check push latency exactly.
    drive(8'hA5, 1'b1, 0, PUSH_N);
    chk("a5_pre_vld", 32'(o_valid), 32'd0);
    tick();
    chk("a5_vld", 32'(o_valid), 32'd1);
    chk("a5_dat", 32'(o_data), 32'hA5);
    chk("a5_cnt", 32'(o_count), 32'd1);
    chk("a5_ovr", 32'(o_overrun), 32'd0);
    repeat (FRM - PUSH_N - 1) tick();
    model_frame(8'hA5, 1'b1, 0);
    verify("a5");
    pop_n(1, "a5_pop");

    // Back-to-back frames then per-cycle pops.
    frame(8'h01, 1'b1, 0);
    frame(8'h02, 1'b1, 0);
    frame(8'h03, 1'b1, 0);
    verify("b2b");
    chk("b2b_head", 32'(o_data), 32'h01);
    pop_n(3, "b2b_pop");
    chk("b2b_empty", 32'(o_valid), 32'd0);

    // Overrun with 9 frames.
    for (int i = 0; i < 9; i++)
      frame(8'(8'h10 + i), 1'b1, 0);
    verify("ovr");
    chk("ovr_cnt8", 32'(o_count), 32'd8);
    chk("ovr_flag", 32'(o_overrun), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("ovr_seq", 32'(o_data), 32'(8'h10 + i));
      pop_n(1, "ovr_pop");
    end
    clr();
    verify("ovr_clr");

    // Glitch shorter than half a bit.
    glitch();
    verify("glitch");

    // Full FIFO, pop coincides with stop sample.
    for (int i = 0; i < 8; i++)
      frame(8'(8'h10 + i), 1'b1, 0);
    frame(8'h18, 1'b1, 1);
    verify("fullpop");
    chk("fullpop_head", 32'(o_data), 32'h11);
    chk("fullpop_cnt", 32'(o_count), 32'd8);
    chk("fullpop_ovr", 32'(o_overrun), 32'd0);
    pop_n(8, "fullpop_drain");

`ifdef UART_RX_FRAMING_CHECK_EN
    frame(8'h55, 1'b0, 0);
    verify("ferr");
    chk("ferr_flag", 32'(o_frame_err), 32'd1);
    frame(8'h66, 1'b1, 0);
    chk("ferr_next", 32'(o_data), 32'h66);
    pop_n(1, "ferr_pop");
    clr();
    verify("ferr_clr");
`endif

    // Reset mid-DATA after 4 data bits.
    frame(8'h77, 1'b1, 0);
    drive(8'hC3, 1'b1, 0, 27 + 4 * CPB + 2);
    chk("mid_busy", 32'(o_busy), 32'd1);
    i_rx = 1'b1;
    i_rst = 1'b1;
    #1;
    q.delete();
    m_ovr = 0;
    m_ferr = 0;
    verify("midrst");
    tick();
    i_rst = 1'b0;
    tick();
    frame(8'h3C, 1'b1, 0);
    verify("midrst_3c");
    chk("midrst_3c_dat", 32'(o_data), 32'h3C);

    // Random mix.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        logic [7:0] b;
        logic sv;
        bit pa;
        b  = 8'($urandom);
        sv = ($urandom_range(0, 7) != 0);
        pa = ($urandom_range(0, 2) == 0);
        frame(b, sv, pa);
      end else if (op <= 6) begin
        pop_n(1, "rnd_pop");
      end else if (op == 7) begin
        pop_n($urandom_range(2, 4), "rnd_burst");
      end else if (op == 8) begin
        clr();
      end else begin
        glitch();
      end
      verify("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
